// File: rtl/status_pkg.sv
// Constants, FSM encoding and the leading-zero mask helper shared by the
// status-bar BCD latch and its serial conversion engine.
package status_pkg;
    localparam int SCORE_DIGITS = 5;
    localparam int SMALL_DIGITS = 3;
    localparam int ENGINE_W     = 16;
    localparam int ACC_W        = 4 * SCORE_DIGITS;
    localparam int SMALL_W      = 4 * SMALL_DIGITS;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    // Takes only the digits above the ones digit: the ones digit is never blanked.
    function automatic logic [SCORE_DIGITS-1:0] lz_mask(input logic [ACC_W-1:4] upper);
        logic run_zero;
        lz_mask  = '0;
        run_zero = 1'b1;
        for (int i = SCORE_DIGITS - 1; i > 0; i--) begin
            run_zero   = run_zero & (upper[4*i +: 4] == 4'd0);
            lz_mask[i] = run_zero;
        end
    endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble engine: one bit per cycle, 16 cycles per conversion.
// done_o marks the cycle whose closing edge produces the final value on bcd_o.
module bin2bcd_serial
    import status_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ENGINE_W-1:0] bin_i,
    output logic                done_o,
    output logic [ACC_W-1:0]    bcd_o
);

    logic [ENGINE_W-1:0] bin_q, bin_d, bin_sh;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_adj, acc_sh;
    logic [3:0]          cnt_q, cnt_d;
    logic                run_q, run_d;

    for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_adj
        assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                    acc_q[4*gi +: 4] + 4'd3 : acc_q[4*gi +: 4];
    end

    // The bit shifted out of the accumulator top is always zero for 16-bit inputs.
    assign {acc_sh, bin_sh} = {acc_adj, bin_q} << 1;

    always_comb begin
        bin_d = bin_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            bin_d = bin_i;
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bin_d = bin_sh;
            acc_d = acc_sh;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'hF) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == 4'hF);
    assign bcd_o  = acc_sh;

endmodule

// File: rtl/status_bcd_latch.sv
// Samples score/health/level at the start of vertical blanking, converts them
// one after another on a shared engine and commits all digits and masks together.
module status_bcd_latch
    import status_pkg::*;
#(
    parameter int SCORE_W  = 16,
    parameter int HEALTH_W = 8,
    parameter int LVL_W    = 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                vblnk_in,
    input  logic [SCORE_W-1:0]  score_in,
    input  logic [HEALTH_W-1:0] health_in,
    input  logic [LVL_W-1:0]    lvl_in,
    output logic [19:0]         score_bcd,
    output logic [11:0]         health_bcd,
    output logic [11:0]         lvl_bcd,
    output logic [4:0]          score_blank,
    output logic [2:0]          health_blank,
    output logic [2:0]          lvl_blank,
    output logic                upd,
    output logic                busy
);

    state_t              state_q;
    logic                vblnk_q;
    logic [1:0]          item_q;
    logic [ENGINE_W-1:0] shadow_score_q, shadow_health_q, shadow_lvl_q;
    logic [ACC_W-1:0]    stage_score_q;
    logic [SMALL_W-1:0]  stage_health_q, stage_lvl_q;
    logic [ACC_W-1:0]    score_bcd_q;
    logic [SMALL_W-1:0]  health_bcd_q, lvl_bcd_q;
    logic [SCORE_DIGITS-1:0] score_blank_q;
    logic [SMALL_DIGITS-1:0] health_blank_q, lvl_blank_q;
    logic                upd_q, busy_q;

    logic                start_evt, eng_start, eng_done;
    logic [ENGINE_W-1:0] eng_bin;
    logic [ACC_W-1:0]    eng_bcd;

    assign start_evt = vblnk_in & ~vblnk_q;
    assign eng_start = (state_q == LOAD);

    always_comb begin
        case (item_q)
            2'd0:    eng_bin = shadow_score_q;
            2'd1:    eng_bin = shadow_health_q;
            default: eng_bin = shadow_lvl_q;
        endcase
    end

    bin2bcd_serial u_engine (
        .clk     (clk),
        .rst     (rst),
        .start_i (eng_start),
        .bin_i   (eng_bin),
        .done_o  (eng_done),
        .bcd_o   (eng_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            vblnk_q         <= 1'b0;
            item_q          <= '0;
            shadow_score_q  <= '0;
            shadow_health_q <= '0;
            shadow_lvl_q    <= '0;
            stage_score_q   <= '0;
            stage_health_q  <= '0;
            stage_lvl_q     <= '0;
            score_bcd_q     <= '0;
            health_bcd_q    <= '0;
            lvl_bcd_q       <= '0;
            score_blank_q   <= 5'b11110;
            health_blank_q  <= 3'b110;
            lvl_blank_q     <= 3'b110;
            upd_q           <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            vblnk_q <= vblnk_in;
            upd_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A start event outside IDLE falls through here unseen, so it is never queued.
                    if (start_evt) begin
                        shadow_score_q  <= ENGINE_W'(score_in);
                        shadow_health_q <= ENGINE_W'(health_in);
                        shadow_lvl_q    <= ENGINE_W'(lvl_in);
                        item_q          <= 2'd0;
                        busy_q          <= 1'b1;
                        state_q         <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (eng_done) begin
                        case (item_q)
                            2'd0:    stage_score_q  <= eng_bcd;
                            2'd1:    stage_health_q <= eng_bcd[SMALL_W-1:0];
                            default: stage_lvl_q    <= eng_bcd[SMALL_W-1:0];
                        endcase
                        if (item_q < 2'd2) begin
                            item_q  <= item_q + 2'd1;
                            state_q <= LOAD;
                        end else begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    score_bcd_q    <= stage_score_q;
                    health_bcd_q   <= stage_health_q;
                    lvl_bcd_q      <= stage_lvl_q;
                    score_blank_q  <= lz_mask(stage_score_q[ACC_W-1:4]);
                    health_blank_q <= SMALL_DIGITS'(lz_mask({8'd0, stage_health_q[SMALL_W-1:4]}));
                    lvl_blank_q    <= SMALL_DIGITS'(lz_mask({8'd0, stage_lvl_q[SMALL_W-1:4]}));
                    upd_q          <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score_bcd    = score_bcd_q;
    assign health_bcd   = health_bcd_q;
    assign lvl_bcd      = lvl_bcd_q;
    assign score_blank  = score_blank_q;
    assign health_blank = health_blank_q;
    assign lvl_blank    = lvl_blank_q;
    assign upd          = upd_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_status_bcd_latch.sv
// Scoreboard bench for status_bcd_latch: expected frames are queued at the
// start event and compared against the outputs on each upd pulse.
module tb_status_bcd_latch;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        vblnk_in  = 1'b0;
    logic [15:0] score_in  = '0;
    logic [7:0]  health_in = '0;
    logic [7:0]  lvl_in    = '0;
    logic [19:0] score_bcd;
    logic [11:0] health_bcd, lvl_bcd;
    logic [4:0]  score_blank;
    logic [2:0]  health_blank, lvl_blank;
    logic        upd, busy;

    always #5 clk = ~clk;

    status_bcd_latch #(.SCORE_W(16), .HEALTH_W(8), .LVL_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .vblnk_in     (vblnk_in),
        .score_in     (score_in),
        .health_in    (health_in),
        .lvl_in       (lvl_in),
        .score_bcd    (score_bcd),
        .health_bcd   (health_bcd),
        .lvl_bcd      (lvl_bcd),
        .score_blank  (score_blank),
        .health_blank (health_blank),
        .lvl_blank    (lvl_blank),
        .upd          (upd),
        .busy         (busy)
    );

    typedef struct packed {
        logic [19:0] sb;
        logic [11:0] hb;
        logic [11:0] lb;
        logic [4:0]  sm;
        logic [2:0]  hm;
        logic [2:0]  lm;
    } exp_t;

    exp_t exp_q[$];
    int   checks_cnt    = 0;
    int   fail_cnt      = 0;
    int   upd_cnt       = 0;
    int   commit_expect = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        int d;
        ref_bcd = '0;
        d = v;
        for (int i = 0; i < 5; i++) begin
            ref_bcd[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
    endfunction

    // Digit i is blank exactly when the value is below 10^i.
    function automatic logic [4:0] ref_blank(input int v);
        int p;
        ref_blank = '0;
        p = 1;
        for (int i = 1; i < 5; i++) begin
            p = p * 10;
            ref_blank[i] = (v < p);
        end
    endfunction

    task automatic start_frame(input int s, input int h, input int l);
        exp_t e;
        score_in  = 16'(s);
        health_in = 8'(h);
        lvl_in    = 8'(l);
        e.sb = ref_bcd(s);
        e.hb = 12'(ref_bcd(h));
        e.lb = 12'(ref_bcd(l));
        e.sm = ref_blank(s);
        e.hm = 3'(ref_blank(h));
        e.lm = 3'(ref_blank(l));
        exp_q.push_back(e);
        commit_expect++;
        vblnk_in = 1'b1;
    endtask

    // mode 0 plain, 1 score change at t+10, 2 second start at t+20, 3 reset at t+30
    task automatic wait_upd(input int mode);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vblnk_in = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (mode == 1 && k == 10) score_in = 16'd99;
            if (mode == 2 && k == 19) vblnk_in = 1'b1;
            if (mode == 2 && k == 20) vblnk_in = 1'b0;
            if (k == 26) check("busy_mid", busy, 1);
            if (mode == 3 && k == 30) begin
                rst = 1'b0;
                #1;
                check("rst_score_bcd", score_bcd, 0);
                check("rst_health_bcd", health_bcd, 0);
                check("rst_score_blank", score_blank, 5'b11110);
                check("rst_lvl_blank", lvl_blank, 3'b110);
                check("rst_busy", busy, 0);
                check("rst_upd", upd, 0);
                commit_expect = commit_expect - exp_q.size();
                exp_q.delete();
                return;
            end
            if (upd) seen = 1'b1;
        end
        check("upd_latency", k, 52);
        check("busy_at_commit", busy, 0);
        @(negedge clk);
        check("upd_width", upd, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (upd) begin
            upd_cnt++;
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("upd %0d score=%h health=%h lvl=%h blanks=%b/%b/%b",
                         upd_cnt, score_bcd, health_bcd, lvl_bcd, score_blank, health_blank, lvl_blank);
                check("score_bcd", score_bcd, e.sb);
                check("health_bcd", health_bcd, e.hb);
                check("lvl_bcd", lvl_bcd, e.lb);
                check("score_blank", score_blank, e.sm);
                check("health_blank", health_blank, e.hm);
                check("lvl_blank", lvl_blank, e.lm);
            end
        end
    end

    initial begin
        int n;
        int s, h, l;
        repeat (3) @(negedge clk);
        check("reset_score_bcd", score_bcd, 0);
        check("reset_lvl_bcd", lvl_bcd, 0);
        check("reset_score_blank", score_blank, 5'b11110);
        check("reset_health_blank", health_blank, 3'b110);
        check("reset_upd", upd, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);

        start_frame(12345, 100, 7);
        wait_upd(0);
        start_frame(65535, 0, 0);
        wait_upd(0);
        start_frame(42, 5, 9);
        wait_upd(1);

        n = upd_cnt;
        start_frame(500, 20, 10);
        wait_upd(2);
        repeat (60) @(negedge clk);
        check("dbl_start_upd_cnt", upd_cnt - n, 1);
        start_frame(1, 2, 3);
        wait_upd(0);

        n = upd_cnt;
        start_frame(777, 50, 60);
        wait_upd(3);
        @(negedge clk);
        start_frame(9, 255, 99);
        @(negedge clk);
        rst = 1'b1;
        check("no_upd_during_reset", upd_cnt - n, 0);
        wait_upd(0);

        for (int i = 0; i < 1000; i++) begin
            s = $urandom_range(0, 65535);
            h = $urandom_range(0, 255);
            l = $urandom_range(0, 255);
            if (i % 9 == 0) s = (i % 2 == 0) ? 0 : 65535;
            if (i % 11 == 0) h = 0;
            if (i % 13 == 0) l = 10;
            start_frame(s, h, l);
            wait_upd(0);
        end

        repeat (5) @(negedge clk);
        check("upd_total", upd_cnt, commit_expect);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
